// File: rtl/hex_display_pkg.sv
// Shared types and the active-low 7-segment glyph table for hex_display_bank.
package hex_display_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Bits 6:0 = g..a, active low; index = hex digit value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_display_bank_decode.sv
// Single-digit combinational decoder: glyph lookup, dp, leading-zero blank and forced-dark override.
module hex_digit_decode
  import hex_display_pkg::*;
(
  input  nibble_t nibble,
  input  logic    dp,
  input  logic    blank,
  input  logic    dark,
  output seg_t    seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!dark) begin
      seg[7]   = ~dp;
      seg[6:0] = blank ? 7'h7F : SEG_LUT[nibble];
    end
  end

endmodule

// File: rtl/hex_display_bank.sv
// Registered multi-digit active-low 7-segment driver with leading-zero blanking and blink.
// Optional dimming PWM and brightness port enabled by HEX_DISPLAY_BANK_DIM_EN.
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_SEGMENTS    = 8,
  parameter int BITS_PER_NIBBLE = 4,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [NUM_DIGITS*BITS_PER_NIBBLE-1:0] value,
  input  logic [NUM_DIGITS-1:0]                 dp_mask,
  input  logic [NUM_DIGITS-1:0]                 blink_mask,
  input  logic                                  blank_lz,
`ifdef HEX_DISPLAY_BANK_DIM_EN
  input  logic [3:0]                            brightness,
`endif
  output logic                                  ack,
  output logic [NUM_DIGITS*NUM_SEGMENTS-1:0]    SS
);

  localparam int VW    = NUM_DIGITS * BITS_PER_NIBBLE;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [VW-1:0]                      value_q, value_d;
  logic [NUM_DIGITS-1:0]              dp_mask_q, dp_mask_d;
  logic [NUM_DIGITS-1:0]              blink_mask_q, blink_mask_d;
  logic                               blank_lz_q, blank_lz_d;
  logic                               load_q, load_d;
  logic                               ack_q, ack_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS*NUM_SEGMENTS-1:0] ss_q, ss_d;
  logic [NUM_DIGITS-1:0]              blank;
  logic                               dim_off;
  seg_t                               seg_w [NUM_DIGITS];

  always_comb begin
    value_d      = value_q;
    dp_mask_d    = dp_mask_q;
    blink_mask_d = blink_mask_q;
    blank_lz_d   = blank_lz_q;
    if (load) begin
      value_d      = value;
      dp_mask_d    = dp_mask;
      blink_mask_d = blink_mask;
      blank_lz_d   = blank_lz;
    end
    load_d = load;
    ack_d  = load_q;
  end

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d         = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Walk from the most significant digit down; a digit blanks while the zero run is unbroken.
  always_comb begin
    logic        zero_run;
    int unsigned idx;
    zero_run = 1'b1;
    blank    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx         = NUM_DIGITS - 1 - k;
      zero_run    = zero_run & (value_q[idx*BITS_PER_NIBBLE +: BITS_PER_NIBBLE] == '0);
      blank[idx]  = blank_lz_q & zero_run & (idx != 0);
    end
  end

`ifdef HEX_DISPLAY_BANK_DIM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    dim_off   = !((pwm_cnt_q < brightness) || (brightness == 4'hF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
`else
  always_comb dim_off = 1'b0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_digit_decode u_dec (
      .nibble (nibble_t'(value_q[g*BITS_PER_NIBBLE +: BITS_PER_NIBBLE])),
      .dp     (dp_mask_q[g]),
      .blank  (blank[g]),
      .dark   ((blink_phase_q & blink_mask_q[g]) | dim_off),
      .seg    (seg_w[g])
    );
  end

  always_comb begin
    ss_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      ss_d[i*NUM_SEGMENTS +: NUM_SEGMENTS] = NUM_SEGMENTS'(seg_w[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q       <= '0;
      dp_mask_q     <= '0;
      blink_mask_q  <= '0;
      blank_lz_q    <= 1'b0;
      load_q        <= 1'b0;
      ack_q         <= 1'b0;
      cnt_q         <= '0;
      blink_phase_q <= 1'b0;
      ss_q          <= '1;
    end else begin
      value_q       <= value_d;
      dp_mask_q     <= dp_mask_d;
      blink_mask_q  <= blink_mask_d;
      blank_lz_q    <= blank_lz_d;
      load_q        <= load_d;
      ack_q         <= ack_d;
      cnt_q         <= cnt_d;
      blink_phase_q <= blink_phase_d;
      ss_q          <= ss_d;
    end
  end

  assign ack = ack_q;
  assign SS  = ss_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank (6 digits, blink half-period 4 cycles).
module tb_hex_display_bank;

  localparam int ND = 6;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [23:0]   value;
  logic [5:0]    dp_mask;
  logic [5:0]    blink_mask;
  logic          blank_lz;
  logic          ack;
  logic [47:0]   SS;
`ifdef HEX_DISPLAY_BANK_DIM_EN
  logic [3:0]    brightness = 4'hF;
`endif

  hex_display_bank #(
    .NUM_DIGITS      (ND),
    .NUM_SEGMENTS    (8),
    .BITS_PER_NIBBLE (4),
    .BLINK_DIV       (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
`ifdef HEX_DISPLAY_BANK_DIM_EN
    .brightness (brightness),
`endif
    .ack        (ack),
    .SS         (SS)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: what has been captured, and how many edges since reset released.
  logic [23:0] cap_v;
  logic [5:0]  cap_dp, cap_bm;
  logic        cap_lz;
  logic        prev_load;
  int          k;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [47:0] show(input logic [23:0] v, input logic [5:0] dp,
                                       input logic [5:0] bm, input logic lz, input logic ph);
    logic [47:0] r;
    logic [7:0]  s;
    r = '1;
    for (int i = 0; i < ND; i++) begin
      if (ph && bm[i]) s = 8'hFF;
      else begin
        if (lz && i > 0 && (v >> (4*i)) == 24'd0) s[6:0] = 7'h7F;
        else                                      s[6:0] = glyph[(v >> (4*i)) & 24'hF][6:0];
        s[7] = ~dp[i];
      end
      r[i*8 +: 8] = s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    cap_v = '0; cap_dp = '0; cap_bm = '0; cap_lz = 1'b0;
    prev_load = 1'b0;
    k = 0;
  endtask

  task automatic step(input logic ld, input logic [23:0] v, input logic [5:0] dp,
                      input logic [5:0] bm, input logic lz);
    logic [47:0] exp_ss;
    logic        exp_ack;
    load = ld; value = v; dp_mask = dp; blink_mask = bm; blank_lz = lz;
    @(posedge clk);
    exp_ss  = show(cap_v, cap_dp, cap_bm, cap_lz, ((k / BD) % 2) == 1);
    exp_ack = prev_load;
    if (ld) begin
      cap_v = v; cap_dp = dp; cap_bm = bm; cap_lz = lz;
    end
    prev_load = ld;
    k++;
    #1;
    chk("ss", SS, exp_ss);
    chk("ack", {47'd0, ack}, {47'd0, exp_ack});
  endtask

  initial begin
    logic [23:0] rv;
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blink_mask = '0; blank_lz = 1'b0;
    model_reset();
    #2;
    chk("reset_ss", SS, 48'hFFFF_FFFF_FFFF);
    chk("reset_ack", {47'd0, ack}, 48'd0);
    @(negedge clk); rst = 1'b0;

    // Plain decode, no blanking
    step(1'b1, 24'h0123AB, 6'b0, 6'b0, 1'b0);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    chk("dec_0123AB", SS, 48'hC0F9A4B08883);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);

    // Leading-zero suppression with dp on a digit
    step(1'b1, 24'h000450, 6'b000100, 6'b0, 1'b1);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    chk("lz_000450", SS, 48'hFFFFFF1992C0);
    step(1'b1, 24'h000000, 6'b0, 6'b0, 1'b1);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    chk("lz_zero", SS, 48'hFFFFFFFFFFC0);
    step(1'b1, 24'h000000, 6'b100001, 6'b0, 1'b1);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    chk("lz_dp_blank", SS, 48'h7FFFFFFFFF40);

    // Blink on digit 0 with a mid-period reload
    step(1'b1, 24'h000008, 6'b0, 6'b000001, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    step(1'b1, 24'h000008, 6'b0, 6'b000001, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    step(1'b1, 24'h0, 6'b0, 6'b0, 1'b0);

    // Back-to-back loads
    step(1'b1, 24'h000001, 6'b0, 6'b0, 1'b0);
    step(1'b1, 24'h000002, 6'b0, 6'b0, 1'b0);
    chk("b2b_d0_1", {40'd0, SS[7:0]}, {40'd0, 8'hF9});
    step(1'b1, 24'h000003, 6'b0, 6'b0, 1'b0);
    chk("b2b_d0_2", {40'd0, SS[7:0]}, {40'd0, 8'hA4});
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    chk("b2b_d0_3", {40'd0, SS[7:0]}, {40'd0, 8'hB0});
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);

    // Reset asserted between edges clears the display at once
    step(1'b1, 24'hABCDEF, 6'h3F, 6'b0, 1'b0);
    step(1'b0, 24'h0, 6'b0, 6'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_ss", SS, 48'hFFFF_FFFF_FFFF);
    chk("midrun_rst_ack", {47'd0, ack}, 48'd0);
    @(negedge clk); rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rv = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
      step(1'($urandom_range(0, 1)), rv, 6'($urandom), 6'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
Name: hex_display_bank

Overview:
- Registered driver for NUM_DIGITS active-low 7-segment displays plus decimal points, e.g. the DE10 HEX0..HEX5 bank.
- Captures a packed hex word on a load strobe and acknowledges it. Optionally suppresses leading zeros and blinks selected digits from an internal prescaler.
- Sits between user logic (counters, debug registers) and the board seven-segment pins.

Parameters:
- NUM_DIGITS, 6, number of digits driven; at least 1.
- NUM_SEGMENTS, 8, segments per digit; bit 7 = dp, bits 6:0 = g..a.
- BITS_PER_NIBBLE, 4, value bits per digit.
- BLINK_DIV, 25000000, clock cycles per blink half-period; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture strobe, sampled on rising clk.
- value  in  NUM_DIGITS*BITS_PER_NIBBLE  packed digits; digit 0 = LSBs = rightmost.
- dp_mask  in  NUM_DIGITS  1 = dp lit on that digit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- blank_lz  in  1  1 = leading-zero suppression.
- ack  out  1  one-cycle pulse: SS now shows the captured data.
- SS  out  NUM_DIGITS*NUM_SEGMENTS  active-low segments; digit i at [i*8 +: 8].

Behaviour:
- Reset:
  - All capture registers = 0.
  - Blink counter = 0; blink_phase = 0 (visible).
  - ack = 0.
  - SS = all ones (every segment dark).
- Capture (edge N with load=1): value, dp_mask, blink_mask and blank_lz are registered. ack=1 and SS updated after edge N+1. Latency is 1 cycle from capture.
- Back-to-back loads: each one is captured. ack stays high every cycle while load was high one cycle earlier.
- With load=0: registers hold and ack=0.
- Decode, active low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (bits 6:0 shown with bit7=1).
- Decimal point: SS bit 7 of digit i = ~dp_mask_q[i].
- Leading-zero suppression (blank_lz_q=1):
  - Digit i with i>=1 is blanked (bits 6:0 = 1) when it and every higher digit are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - The dp of a blanked digit still follows dp_mask.
- Blink counter:
  - Counts 0..BLINK_DIV-1 every cycle. At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
  - With BLINK_DIV=1, blink_phase toggles every cycle.
  - Only rst resets the counter. load does not disturb it.
- Blink output: when blink_phase=1, all 8 bits of each digit with blink_mask_q[i]=1 are forced to 1, dp included.
- Priority per digit: blink-off > leading-zero blank > decode.
- SS is fully registered, with no combinational path from inputs to SS.
- Reset mid-operation clears the display to dark immediately, without waiting for a clock edge.

Optional Feature:
- Macro: HEX_DISPLAY_BANK_DIM_EN.
- When defined:
  - Extra port brightness  in  4, plus a free-running 4-bit PWM counter reset to 0.
  - All segments are lit only when pwm_cnt < brightness, or always when brightness=4'hF.
  - brightness=0 keeps the display dark, except SS stays registered.
  - Dimming gates after blink and blanking.
- When undefined: no port, no counter; output is identical to brightness=4'hF.

Decomposition:
- Package hex_display_pkg holds:
  - SEG_LUT constant: 16 x 7-bit active-low patterns above.
  - typedef seg_t (logic [7:0]) and nibble_t (logic [3:0]).
  - SEG_BLANK = 8'hFF.
- Sub-module hex_digit_decode (combinational): inputs nibble, dp, blank, dark; output seg_t. It is instantiated NUM_DIGITS times in a generate loop.
- Leading-zero chain, blink prescaler and output registers stay in the top.

Test Plan (NUM_DIGITS=6, BLINK_DIV=4):
- Reset asserted mid-run, before any clock edge → SS=48'hFFFFFFFFFFFF, ack=0.
- load=1 with value=24'h0123AB, blank_lz=0, dp_mask=0, masks 0 → one cycle later ack=1, SS=C0_F9_A4_B0_88_83 (digit5..0). The next cycle ack=0.
- value=24'h000450, blank_lz=1, dp_mask=6'b000100 → digits 5,4,3 = FF, digit2 = 19 (4 with dp lit), digit1 = 92, digit0 = C0. value=0 → only digit0 = C0.
- blink_mask=6'b000001, value=24'h000008 → digit0 alternates 80 / FF every 4 cycles, 8-cycle period. Other digits are steady. A reload mid-period does not shift the phase.
- load held high 3 cycles with values 1,2,3 → ack is high 3 consecutive cycles, and digit0 reads F9, A4, B0 in successive cycles.
- With HEX_DISPLAY_BANK_DIM_EN, brightness=4 → each segment output is low for 4 of every 16 cycles. brightness=F → always low. brightness=0 → always FF.
